timer_sched_ctrl: RTL and testbench
===================================

TIMER_SCHED_CTRL -- requirements
Module: timer_sched_ctrl

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 4, number of period entries in the schedule table (power of 2, 2..8).
REQ-002 SHALL have port clk, input, 1, the single clock for all logic.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port cfg_wr, input, 1, one-cycle table write strobe.
REQ-005 SHALL have port cfg_addr, input, log2(NUM_SLOTS), table entry index.
REQ-006 SHALL have port cfg_data, input, 32, period value for the entry.
REQ-007 SHALL have ports start, stop and loop_en, input, 1 each: begin sequence, abort, and repeat table after the last slot.
REQ-008 SHALL have port tmr_irq, input, 1, interrupt from the timer slave.
REQ-009 SHALL have ports tmr_address (3), tmr_chipselect (1), tmr_write_n (1) and tmr_writedata (16), output, forming the Avalon-MM write master to the timer slave.
REQ-010 SHALL have ports busy (1), slot_idx (log2 NUM_SLOTS), slot_done (1) and seq_done (1), output, giving status.

Function
REQ-011 Timer map SHALL be: 0 status, 1 control, 2 period_l, 3 period_h; all writes complete in one cycle with no wait states.
REQ-012 Control words SHALL be START = 0x0005 (start, interrupt enable, one-shot) and STOP = 0x0008.
REQ-013 States SHALL be IDLE, WR_PL, WR_PH, WR_CTRL, WAIT_IRQ, CLR_STS, NEXT, ABORT; each WR_*/CLR_STS/ABORT state SHALL drive exactly one write cycle with tmr_chipselect=1 and tmr_write_n=0.
REQ-014 IDLE + start SHALL set slot_idx=0 and go to NEXT-evaluation of slot 0, with busy=1 from the following cycle.
REQ-015 Per non-zero slot SHALL issue: WR_PL (period[15:0]) -> WR_PH (period[31:16]) -> WR_CTRL (START) on consecutive cycles, then WAIT_IRQ.
REQ-016 WAIT_IRQ + tmr_irq SHALL go to CLR_STS (status write, data 0x0000), then pulse slot_done for 1 cycle and advance slot_idx.
REQ-017 A slot with period 0 SHALL be skipped (no timer writes, no slot_done), costing 1 cycle.
REQ-018 After the last slot, loop_en=1 SHALL wrap slot_idx to 0 and continue; loop_en=0 SHALL pulse seq_done for 1 cycle and return to IDLE with busy=0.
REQ-019 An all-zero table SHALL pulse seq_done within NUM_SLOTS+1 cycles of start, with no timer writes; with loop_en=1 it SHALL instead terminate as if loop_en=0.
REQ-020 stop in any non-IDLE state SHALL take priority: go to ABORT (control STOP), then CLR_STS, then IDLE, with no slot_done and no seq_done.
REQ-021 start while busy, and stop in IDLE, SHALL be ignored; start and stop together in IDLE SHALL not start.
REQ-022 cfg_wr while busy SHALL be ignored; cfg_wr in IDLE SHALL update the entry on the next clock edge.
REQ-023 When not writing, tmr_chipselect SHALL be 0, tmr_write_n 1, tmr_address 0 and tmr_writedata 0.

Reset
REQ-024 Reset SHALL force IDLE, busy=0, slot_idx=0, slot_done=0, seq_done=0, tmr_chipselect=0, tmr_write_n=1, tmr_address=0 and tmr_writedata=0.
REQ-025 Reset SHALL clear all table entries to 0.
REQ-026 Reset mid-sequence SHALL abort immediately, with no further timer writes.

Structure
REQ-027 A shared package SHALL hold the state enum, the timer register offsets (0-3) and the START/STOP control constants.
REQ-028 The period table (NUM_SLOTS x 32 registers, write port and read mux) SHALL be sub-module timer_sched_table; the FSM and master drive stay in the top.

Verification
REQ-029 Table {1000, 0, 0x0002_0000, 5}, loop_en=0, start -> per non-zero slot, writes 2/3/1 with data (0x03E8, 0x0000, 0x0005), (0x0000, 0x0002, 0x0005) and (0x0005, 0x0000, 0x0005); 3 slot_done pulses; 1 seq_done.
REQ-030 Slot 0 = 10 and tmr_irq raised 7 cycles after WR_CTRL -> CLR_STS write to address 0 on the next cycle, then slot_done 1 cycle later.
REQ-031 stop asserted during WAIT_IRQ -> control write 0x0008, then status write, then busy=0; no slot_done and no seq_done.
REQ-032 All-zero table, start -> seq_done within 5 cycles (NUM_SLOTS=4) and tmr_chipselect never asserted.
REQ-033 loop_en=1 with two non-zero slots -> slot_idx sequence 0,1,0,1 and no seq_done until loop_en deasserted.
REQ-034 cfg_wr while busy, and reset asserted in WR_PH -> table unchanged, and all outputs at reset values asynchronously.

Source files
------------

// File: rtl/timer_sched_ctrl_pkg.sv
// rtl/timer_sched_ctrl_pkg.sv - shared types and constants for the timer scheduler
// Purpose: state encoding of the scheduler FSM, register offsets of the
//          Avalon-MM timer slave and the control words written to it.
// Ports:   none (package).
package timer_sched_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_PL,
    ST_WR_PH,
    ST_WR_CTRL,
    ST_WAIT_IRQ,
    ST_CLR_STS,
    ST_NEXT,
    ST_ABORT
  } state_t;

  // Timer slave register map (word offsets)
  localparam logic [2:0] TMR_REG_STATUS   = 3'd0;
  localparam logic [2:0] TMR_REG_CONTROL  = 3'd1;
  localparam logic [2:0] TMR_REG_PERIOD_L = 3'd2;
  localparam logic [2:0] TMR_REG_PERIOD_H = 3'd3;

  // START = start | irq enable | one-shot ; STOP = stop bit
  localparam logic [15:0] TMR_CTRL_START = 16'h0005;
  localparam logic [15:0] TMR_CTRL_STOP  = 16'h0008;

endpackage

// File: rtl/timer_sched_table.sv
// rtl/timer_sched_table.sv - period table for the timer scheduler
// Purpose: NUM_SLOTS x 32-bit period registers with one write port and a
//          combinational read mux, plus a flag telling whether any entry is
//          non-zero.
// Ports:   clk, reset_n        clock, asynchronous active-low reset (clears table)
//          wr_en/wr_addr/wr_data  single-cycle entry write
//          rd_addr/rd_data     combinational entry read
//          any_nonzero         at least one entry holds a non-zero period
module timer_sched_table
  import timer_sched_ctrl_pkg::*;
#(
  parameter  int NUM_SLOTS = 4,
  localparam int IDX_W     = $clog2(NUM_SLOTS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [31:0]      wr_data,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [31:0]      rd_data,
  output logic             any_nonzero
);

  logic [31:0] period_q [NUM_SLOTS];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        period_q[i] <= '0;
      end
    end else if (wr_en) begin
      period_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = period_q[rd_addr];

  always_comb begin
    any_nonzero = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      any_nonzero = any_nonzero | (period_q[i] != 32'd0);
    end
  end

endmodule

// File: rtl/timer_sched_ctrl.sv
// rtl/timer_sched_ctrl.sv - sequences one-shot timer periods from a table
// Purpose: walks the period table slot by slot; for each non-zero period it
//          programs the timer slave (period low, period high, START), waits
//          for the timer interrupt, clears the status register and moves on.
//          Zero slots are skipped in one cycle. Optional looping over the table.
// Ports:   clk, reset_n                      clock, asynchronous active-low reset
//          cfg_wr/cfg_addr/cfg_data           table write (accepted only when idle)
//          start, stop, loop_en               sequence control
//          tmr_irq                            timer interrupt
//          tmr_address/chipselect/write_n/writedata  Avalon-MM write master
//          busy, slot_idx, slot_done, seq_done        status
module timer_sched_ctrl
  import timer_sched_ctrl_pkg::*;
#(
  parameter  int NUM_SLOTS = 4,
  localparam int IDX_W     = $clog2(NUM_SLOTS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cfg_wr,
  input  logic [IDX_W-1:0] cfg_addr,
  input  logic [31:0]      cfg_data,
  input  logic             start,
  input  logic             stop,
  input  logic             loop_en,
  input  logic             tmr_irq,
  output logic [2:0]       tmr_address,
  output logic             tmr_chipselect,
  output logic             tmr_write_n,
  output logic [15:0]      tmr_writedata,
  output logic             busy,
  output logic [IDX_W-1:0] slot_idx,
  output logic             slot_done,
  output logic             seq_done
);

  localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(NUM_SLOTS - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] slot_idx_q, slot_idx_d;
  logic             abort_q, abort_d;
  logic             slot_done_q, slot_done_d;
  logic             seq_done_q, seq_done_d;

  logic [31:0]      period;
  logic             any_nonzero;

  state_t           adv_state;
  logic [IDX_W-1:0] adv_idx;
  logic             adv_seq_done;

  timer_sched_table #(.NUM_SLOTS(NUM_SLOTS)) u_table (
    .clk         (clk),
    .reset_n     (reset_n),
    .wr_en       (cfg_wr && (state_q == ST_IDLE)),
    .wr_addr     (cfg_addr),
    .wr_data     (cfg_data),
    .rd_addr     (slot_idx_q),
    .rd_data     (period),
    .any_nonzero (any_nonzero)
  );

  // Where to go once the current slot is finished (fired or skipped).
  // Wrapping needs at least one non-zero entry, otherwise an all-zero table
  // would spin forever with loop_en set.
  always_comb begin
    adv_state    = ST_IDLE;
    adv_idx      = slot_idx_q;
    adv_seq_done = 1'b0;
    if (slot_idx_q != LAST_SLOT) begin
      adv_state = ST_NEXT;
      adv_idx   = slot_idx_q + IDX_W'(1);
    end else if (loop_en && any_nonzero) begin
      adv_state = ST_NEXT;
      adv_idx   = '0;
    end else begin
      adv_seq_done = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    slot_idx_d  = slot_idx_q;
    abort_d     = abort_q;
    slot_done_d = 1'b0;
    seq_done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          slot_idx_d = '0;
          abort_d    = 1'b0;
          state_d    = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (period != 32'd0) begin
          state_d = ST_WR_PL;
        end else begin
          state_d    = adv_state;
          slot_idx_d = adv_idx;
          seq_done_d = adv_seq_done;
        end
      end
      ST_WR_PL:    state_d = ST_WR_PH;
      ST_WR_PH:    state_d = ST_WR_CTRL;
      ST_WR_CTRL:  state_d = ST_WAIT_IRQ;
      ST_WAIT_IRQ: begin
        if (tmr_irq) begin
          state_d = ST_CLR_STS;
        end
      end
      ST_CLR_STS: begin
        // Status clear is shared by the normal slot end and the abort path.
        if (abort_q) begin
          abort_d = 1'b0;
          state_d = ST_IDLE;
        end else begin
          slot_done_d = 1'b1;
          state_d     = adv_state;
          slot_idx_d  = adv_idx;
          seq_done_d  = adv_seq_done;
        end
      end
      ST_ABORT:    state_d = ST_CLR_STS;
      default:     state_d = ST_IDLE;
    endcase

    // stop overrides everything once a sequence runs, but an abort already
    // in progress just finishes its STOP/clear writes.
    if (stop && (state_q != ST_IDLE) && (state_q != ST_ABORT) && !abort_q) begin
      state_d     = ST_ABORT;
      abort_d     = 1'b1;
      slot_idx_d  = slot_idx_q;
      slot_done_d = 1'b0;
      seq_done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      slot_idx_q  <= '0;
      abort_q     <= 1'b0;
      slot_done_q <= 1'b0;
      seq_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_idx_q  <= slot_idx_d;
      abort_q     <= abort_d;
      slot_done_q <= slot_done_d;
      seq_done_q  <= seq_done_d;
    end
  end

  // Write master decode: one zero-wait write per write state, idle bus
  // otherwise. Decoded from the registered state so reset clears it at once.
  always_comb begin
    tmr_chipselect = 1'b0;
    tmr_write_n    = 1'b1;
    tmr_address    = 3'd0;
    tmr_writedata  = 16'h0000;
    case (state_q)
      ST_WR_PL: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = TMR_REG_PERIOD_L;
        tmr_writedata  = period[15:0];
      end
      ST_WR_PH: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = TMR_REG_PERIOD_H;
        tmr_writedata  = period[31:16];
      end
      ST_WR_CTRL: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = TMR_REG_CONTROL;
        tmr_writedata  = TMR_CTRL_START;
      end
      ST_CLR_STS: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = TMR_REG_STATUS;
        tmr_writedata  = 16'h0000;
      end
      ST_ABORT: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = TMR_REG_CONTROL;
        tmr_writedata  = TMR_CTRL_STOP;
      end
      default: begin
        tmr_chipselect = 1'b0;
      end
    endcase
  end

  assign busy      = (state_q != ST_IDLE);
  assign slot_idx  = slot_idx_q;
  assign slot_done = slot_done_q;
  assign seq_done  = seq_done_q;

endmodule

// File: tb/tb_timer_sched_ctrl.sv
// tb/tb_timer_sched_ctrl.sv - self-checking bench for timer_sched_ctrl
module tb_timer_sched_ctrl;

  localparam int N = 4;

  logic        clk;
  logic        reset_n;
  logic        cfg_wr;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_data;
  logic        start;
  logic        stop;
  logic        loop_en;
  logic        tmr_irq;
  logic [2:0]  tmr_address;
  logic        tmr_chipselect;
  logic        tmr_write_n;
  logic [15:0] tmr_writedata;
  logic        busy;
  logic [1:0]  slot_idx;
  logic        slot_done;
  logic        seq_done;

  timer_sched_ctrl #(.NUM_SLOTS(N)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cfg_wr         (cfg_wr),
    .cfg_addr       (cfg_addr),
    .cfg_data       (cfg_data),
    .start          (start),
    .stop           (stop),
    .loop_en        (loop_en),
    .tmr_irq        (tmr_irq),
    .tmr_address    (tmr_address),
    .tmr_chipselect (tmr_chipselect),
    .tmr_write_n    (tmr_write_n),
    .tmr_writedata  (tmr_writedata),
    .busy           (busy),
    .slot_idx       (slot_idx),
    .slot_done      (slot_done),
    .seq_done       (seq_done)
  );

  // kind: 0 write, 1 slot_done, 2 seq_done, 3 chipselect without write
  typedef struct {
    int cyc;
    int kind;
    int a;
    int d;
    int idx;
  } ev_t;

  ev_t         obs_q[$];
  ev_t         exp_q[$];
  int          cyc;
  int          irq_delay;
  bit          irq_auto;
  int          errors;
  int          checks;
  logic [31:0] ref_tbl [N];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Bus monitor and timer-slave model: irq rises irq_delay cycles after a
  // START write, drops on a status write or a STOP write.
  initial begin
    int cnt;
    cnt = -1;
    tmr_irq = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        tmr_irq = 1'b0;
        cnt = -1;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            tmr_irq = 1'b1;
            cnt = -1;
          end
        end
        if (tmr_chipselect) begin
          obs_q.push_back('{cyc, (tmr_write_n ? 3 : 0), int'(tmr_address),
                            int'(tmr_writedata), int'(slot_idx)});
          if (tmr_address == 3'd0) tmr_irq = 1'b0;
          if (tmr_address == 3'd1 && tmr_writedata == 16'h0008) begin
            tmr_irq = 1'b0;
            cnt = -1;
          end
          if (irq_auto && tmr_address == 3'd1 && tmr_writedata == 16'h0005)
            cnt = irq_delay;
        end
        if (slot_done) obs_q.push_back('{cyc, 1, 0, 0, 0});
        if (seq_done)  obs_q.push_back('{cyc, 2, 0, 0, 0});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_table();
    for (int i = 0; i < N; i++) begin
      cfg_wr = 1'b1;
      cfg_addr = 2'(i);
      cfg_data = ref_tbl[i];
      step();
    end
    cfg_wr = 1'b0;
  endtask

  // Pulse start, then wait (bounded) for the sequence to end.
  task automatic run_seq(input bit lp, output int s, output bit ok);
    obs_q.delete();
    loop_en = lp;
    start = 1'b1;
    s = cyc;
    step();
    start = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      step();
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    step();
    step();
  endtask

  // Reference schedule: a zero slot costs one cycle; a non-zero slot costs
  // one evaluation cycle, three writes, d wait cycles and the status clear,
  // with slot_done on the cycle after the clear.
  task automatic model_seq(input int s, input int d);
    int t;
    exp_q.delete();
    t = s + 1;
    for (int i = 0; i < N; i++) begin
      if (ref_tbl[i] == 32'd0) begin
        t = t + 1;
      end else begin
        exp_q.push_back('{t + 1, 0, 2, int'(ref_tbl[i][15:0]), i});
        exp_q.push_back('{t + 2, 0, 3, int'(ref_tbl[i][31:16]), i});
        exp_q.push_back('{t + 3, 0, 1, 5, i});
        exp_q.push_back('{t + d + 4, 0, 0, 0, i});
        t = t + d + 5;
        exp_q.push_back('{t, 1, 0, 0, 0});
      end
    end
    exp_q.push_back('{t, 2, 0, 0, 0});
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    cfg_wr = 1'b0; cfg_addr = '0; cfg_data = '0;
    start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    irq_auto = 1'b0; irq_delay = 1;
    repeat (3) step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (slot_idx !== 2'd0) begin errors++; $display("FAIL reset_slot_idx: got %0d want 0", slot_idx); end
    checks++; if (slot_done !== 1'b0) begin errors++; $display("FAIL reset_slot_done: got %b want 0", slot_done); end
    checks++; if (seq_done !== 1'b0) begin errors++; $display("FAIL reset_seq_done: got %b want 0", seq_done); end
    checks++; if (tmr_chipselect !== 1'b0) begin errors++; $display("FAIL reset_cs: got %b want 0", tmr_chipselect); end
    checks++; if (tmr_write_n !== 1'b1) begin errors++; $display("FAIL reset_write_n: got %b want 1", tmr_write_n); end
    checks++; if (tmr_address !== 3'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", tmr_address); end
    checks++; if (tmr_writedata !== 16'd0) begin errors++; $display("FAIL reset_data: got %h want 0", tmr_writedata); end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_example();
    int s;
    bit ok;
    ref_tbl[0] = 32'd1000; ref_tbl[1] = 32'd0; ref_tbl[2] = 32'h0002_0000; ref_tbl[3] = 32'd5;
    load_table();
    irq_delay = 3;
    irq_auto = 1'b1;
    run_seq(1'b0, s, ok);
    model_seq(s, 3);
    checks++;
    if (!ok) begin errors++; $display("FAIL example_done: busy still 1 after bound, want 0"); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL example_events: got %0d events want %0d", obs_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i].cyc != exp_q[i].cyc || obs_q[i].kind != exp_q[i].kind || obs_q[i].a != exp_q[i].a ||
            obs_q[i].d != exp_q[i].d || obs_q[i].idx != exp_q[i].idx) begin
          errors++;
          $display("FAIL example_ev%0d: got cyc=%0d kind=%0d a=%0d d=%h idx=%0d want cyc=%0d kind=%0d a=%0d d=%h idx=%0d",
                   i, obs_q[i].cyc - s, obs_q[i].kind, obs_q[i].a, obs_q[i].d, obs_q[i].idx,
                   exp_q[i].cyc - s, exp_q[i].kind, exp_q[i].a, exp_q[i].d, exp_q[i].idx);
        end
      end
    end
  endtask

  task automatic test_all_zero();
    int s;
    bit ok;
    int nwr, nsd, nqd, qcyc;
    // reset must wipe the table loaded by the previous test
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    for (int lp = 0; lp < 2; lp++) begin
      run_seq(lp[0], s, ok);
      nwr = 0; nsd = 0; nqd = 0; qcyc = -1;
      foreach (obs_q[i]) begin
        if (obs_q[i].kind == 0 || obs_q[i].kind == 3) nwr++;
        if (obs_q[i].kind == 1) nsd++;
        if (obs_q[i].kind == 2) begin nqd++; qcyc = obs_q[i].cyc; end
      end
      checks++; if (!ok) begin errors++; $display("FAIL zero_done_loop%0d: busy still 1, want 0", lp); end
      checks++; if (nwr != 0) begin errors++; $display("FAIL zero_writes_loop%0d: got %0d want 0", lp, nwr); end
      checks++; if (nsd != 0) begin errors++; $display("FAIL zero_slot_done_loop%0d: got %0d want 0", lp, nsd); end
      checks++; if (nqd != 1) begin errors++; $display("FAIL zero_seq_done_loop%0d: got %0d want 1", lp, nqd); end
      checks++;
      if (qcyc <= s || qcyc - s > N + 1) begin
        errors++;
        $display("FAIL zero_latency_loop%0d: got %0d cycles want 1..%0d", lp, qcyc - s, N + 1);
      end
    end
  endtask

  task automatic test_irq_timing();
    int s;
    bit ok;
    int c_ctrl, c_clr, c_sd;
    ref_tbl[0] = 32'd10; ref_tbl[1] = 32'd0; ref_tbl[2] = 32'd0; ref_tbl[3] = 32'd0;
    load_table();
    irq_delay = 7;
    irq_auto = 1'b1;
    run_seq(1'b0, s, ok);
    c_ctrl = -100; c_clr = -1; c_sd = -1;
    foreach (obs_q[i]) begin
      if (obs_q[i].kind == 0 && obs_q[i].a == 1 && obs_q[i].d == 5) c_ctrl = obs_q[i].cyc;
      if (obs_q[i].kind == 0 && obs_q[i].a == 0 && obs_q[i].d == 0) c_clr = obs_q[i].cyc;
      if (obs_q[i].kind == 1) c_sd = obs_q[i].cyc;
    end
    checks++; if (!ok) begin errors++; $display("FAIL irq_done: busy still 1, want 0"); end
    checks++;
    if (c_clr != c_ctrl + 8) begin errors++; $display("FAIL irq_clr_cycle: got %0d want %0d", c_clr - s, c_ctrl + 8 - s); end
    checks++;
    if (c_sd != c_ctrl + 9) begin errors++; $display("FAIL irq_slot_done_cycle: got %0d want %0d", c_sd - s, c_ctrl + 9 - s); end
  endtask

  task automatic test_stop();
    int s;
    int nsd, nqd;
    ref_tbl[0] = 32'd50; ref_tbl[1] = 32'd0; ref_tbl[2] = 32'd0; ref_tbl[3] = 32'd0;
    load_table();
    irq_auto = 1'b0;
    obs_q.delete();
    loop_en = 1'b0;
    start = 1'b1;
    s = cyc;
    step();
    start = 1'b0;
    repeat (5) step();
    // in WAIT_IRQ now: a start here must be ignored
    start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (busy !== 1'b1 || slot_idx !== 2'd0) begin errors++; $display("FAIL stop_start_ignored: busy=%b idx=%0d want 1/0", busy, slot_idx); end
    stop = 1'b1;
    step();
    stop = 1'b0;
    checks++;
    if (tmr_chipselect !== 1'b1 || tmr_write_n !== 1'b0 || tmr_address !== 3'd1 || tmr_writedata !== 16'h0008) begin
      errors++;
      $display("FAIL stop_ctrl_write: cs=%b wn=%b a=%0d d=%h want 1/0/1/0008", tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata);
    end
    step();
    checks++;
    if (tmr_chipselect !== 1'b1 || tmr_write_n !== 1'b0 || tmr_address !== 3'd0 || tmr_writedata !== 16'h0000) begin
      errors++;
      $display("FAIL stop_status_write: cs=%b wn=%b a=%0d d=%h want 1/0/0/0000", tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata);
    end
    step();
    checks++; if (busy !== 1'b0 || tmr_chipselect !== 1'b0) begin errors++; $display("FAIL stop_idle: busy=%b cs=%b want 0/0", busy, tmr_chipselect); end
    repeat (3) step();
    nsd = 0; nqd = 0;
    foreach (obs_q[i]) begin
      if (obs_q[i].kind == 1) nsd++;
      if (obs_q[i].kind == 2) nqd++;
    end
    checks++; if (nsd != 0 || nqd != 0) begin errors++; $display("FAIL stop_no_done: slot_done=%0d seq_done=%0d want 0/0", nsd, nqd); end
    checks++; if (obs_q.size() != 5) begin errors++; $display("FAIL stop_write_count: got %0d want 5", obs_q.size()); end
  endtask

  task automatic test_idle_ignore();
    obs_q.delete();
    stop = 1'b1;
    step();
    stop = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_stop: busy=%b want 0", busy); end
    start = 1'b1;
    stop = 1'b1;
    step();
    start = 1'b0;
    stop = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_start_stop: busy=%b want 0", busy); end
    repeat (6) step();
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL idle_no_activity: got %0d events want 0", obs_q.size()); end
  endtask

  task automatic test_loop();
    int pl[$];
    int nqd;
    bit ok;
    ref_tbl[0] = 32'h0000_0030; ref_tbl[1] = 32'h0001_0000; ref_tbl[2] = 32'd0; ref_tbl[3] = 32'd0;
    load_table();
    irq_delay = 2;
    irq_auto = 1'b1;
    obs_q.delete();
    loop_en = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 300; k++) begin
      pl.delete();
      foreach (obs_q[i]) if (obs_q[i].kind == 0 && obs_q[i].a == 2) pl.push_back(obs_q[i].idx);
      if (pl.size() >= 4) break;
      step();
    end
    nqd = 0;
    foreach (obs_q[i]) if (obs_q[i].kind == 2) nqd++;
    checks++; if (nqd != 0) begin errors++; $display("FAIL loop_no_seq_done: got %0d want 0", nqd); end
    checks++;
    if (pl.size() < 4) begin
      errors++;
      $display("FAIL loop_passes: got %0d slot starts want 4", pl.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (pl[i] != (i % 2)) begin errors++; $display("FAIL loop_idx%0d: got %0d want %0d", i, pl[i], i % 2); end
      end
    end
    loop_en = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      step();
      if (!busy) begin ok = 1'b1; break; end
    end
    step();
    step();
    nqd = 0;
    pl.delete();
    foreach (obs_q[i]) begin
      if (obs_q[i].kind == 2) nqd++;
      if (obs_q[i].kind == 0 && obs_q[i].a == 2) pl.push_back(obs_q[i].idx);
    end
    checks++; if (!ok) begin errors++; $display("FAIL loop_end: busy still 1, want 0"); end
    checks++; if (nqd != 1) begin errors++; $display("FAIL loop_seq_done: got %0d want 1", nqd); end
    checks++; if (pl.size() != 4) begin errors++; $display("FAIL loop_total_starts: got %0d want 4", pl.size()); end
  endtask

  task automatic test_cfg_busy();
    int s;
    bit ok;
    int nwr, nbad;
    ref_tbl[0] = 32'd7; ref_tbl[1] = 32'd0; ref_tbl[2] = 32'd0; ref_tbl[3] = 32'd0;
    load_table();
    irq_delay = 1;
    irq_auto = 1'b1;
    loop_en = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    cfg_wr = 1'b1;
    cfg_addr = 2'd1;
    cfg_data = 32'd99;
    step();
    cfg_wr = 1'b0;
    repeat (20) step();
    run_seq(1'b0, s, ok);
    nwr = 0; nbad = 0;
    foreach (obs_q[i]) begin
      if (obs_q[i].kind == 0) nwr++;
      if (obs_q[i].kind == 0 && obs_q[i].idx == 1) nbad++;
    end
    checks++; if (!ok) begin errors++; $display("FAIL cfg_busy_done: busy still 1, want 0"); end
    checks++; if (nwr != 4 || nbad != 0) begin errors++; $display("FAIL cfg_busy_ignored: writes=%0d slot1_writes=%0d want 4/0", nwr, nbad); end
  endtask

  task automatic test_reset_mid();
    bit found;
    ref_tbl[0] = 32'h0001_2345; ref_tbl[1] = 32'd0; ref_tbl[2] = 32'd0; ref_tbl[3] = 32'd0;
    load_table();
    irq_auto = 1'b1;
    irq_delay = 2;
    start = 1'b1;
    step();
    start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (tmr_chipselect && tmr_address == 3'd3) begin found = 1'b1; break; end
    end
    checks++; if (!found) begin errors++; $display("FAIL rstmid_reach_wr_ph: period_h write not seen, want seen"); end
    reset_n = 1'b0;
    #1;
    checks++;
    if (tmr_chipselect !== 1'b0 || tmr_write_n !== 1'b1 || tmr_address !== 3'd0 || tmr_writedata !== 16'd0) begin
      errors++;
      $display("FAIL rstmid_bus: cs=%b wn=%b a=%0d d=%h want 0/1/0/0000", tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata);
    end
    checks++;
    if (busy !== 1'b0 || slot_idx !== 2'd0 || slot_done !== 1'b0 || seq_done !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_status: busy=%b idx=%0d sd=%b qd=%b want 0/0/0/0", busy, slot_idx, slot_done, seq_done);
    end
    obs_q.delete();
    repeat (3) step();
    reset_n = 1'b1;
    repeat (8) step();
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL rstmid_no_writes: got %0d events want 0", obs_q.size()); end
  endtask

  task automatic test_random();
    int s;
    int d;
    bit ok;
    for (int it = 0; it < 5; it++) begin
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 3))
          0:       ref_tbl[i] = 32'd0;
          1:       ref_tbl[i] = {16'($urandom()), 16'd0};
          default: ref_tbl[i] = $urandom();
        endcase
      end
      d = int'($urandom_range(1, 6));
      load_table();
      irq_delay = d;
      irq_auto = 1'b1;
      run_seq(1'b0, s, ok);
      model_seq(s, d);
      checks++;
      if (!ok) begin errors++; $display("FAIL rand%0d_done: busy still 1, want 0", it); end
      checks++;
      if (obs_q.size() != exp_q.size()) begin
        errors++;
        $display("FAIL rand%0d_events: got %0d events want %0d", it, obs_q.size(), exp_q.size());
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          checks++;
          if (obs_q[i].cyc != exp_q[i].cyc || obs_q[i].kind != exp_q[i].kind || obs_q[i].a != exp_q[i].a ||
              obs_q[i].d != exp_q[i].d || obs_q[i].idx != exp_q[i].idx) begin
            errors++;
            $display("FAIL rand%0d_ev%0d: got cyc=%0d kind=%0d a=%0d d=%h idx=%0d want cyc=%0d kind=%0d a=%0d d=%h idx=%0d",
                     it, i, obs_q[i].cyc - s, obs_q[i].kind, obs_q[i].a, obs_q[i].d, obs_q[i].idx,
                     exp_q[i].cyc - s, exp_q[i].kind, exp_q[i].a, exp_q[i].d, exp_q[i].idx);
          end
        end
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_example();
    test_all_zero();
    test_irq_timing();
    test_stop();
    test_idle_ignore();
    test_loop();
    test_cfg_busy();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
